mod_sub_arbiter: RTL and testbench

Round-robin arbiter that shares one `mod_sub` instance (c = (a − b) mod q) among NREQ requesting processing-element lanes. It holds the modulus q in a configuration register, grants at most one request per cycle, and returns a registered result tagged by a one-hot lane vector. It also keeps a completed-operation counter. It sits between the PE lane controllers and the single shared modular subtractor.

---
 rtl/mod_sub_arbiter.sv | 138 +++++++++++++
 tb/tb_mod_sub_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_sub_arbiter.sv
// ---------------------------------------------------------------------------
// mod_sub_arbiter
//   Round-robin arbiter that shares one modular subtractor (c = (a - b) mod q)
//   among NREQ processing-element lanes. Holds the modulus in a local
//   register, grants at most one lane per cycle and returns a registered
//   result tagged with the one-hot lane that owns it. Also counts completed
//   operations.
//
// Ports
//   clk_i        : clock, all state on rising edge
//   rst_i        : asynchronous active-high reset
//   q_we_i       : modulus write strobe
//   q_wdata_i    : modulus write data            [QW]
//   q_o          : current modulus               [QW]
//   req_i        : per-lane request              [NREQ]
//   a_i / b_i    : per-lane operands, lane k at [k*AW +: AW]
//   gnt_o        : one-hot combinational grant   [NREQ]
//   rsp_valid_o  : one-hot registered response tag [NREQ]
//   rsp_data_o   : registered result             [QW]
//   op_cnt_o     : completed-operation counter, wraps [16]
// ---------------------------------------------------------------------------

// mod_sub
//   Combinational c = (a - b) mod q, assuming a, b < q.
//   Ports: a_i, b_i [AW]; q_i [QW]; c_o [QW].
module mod_sub #(
    parameter int AW = 24,
    parameter int QW = 23
) (
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    input  logic [QW-1:0] q_i,
    output logic [QW-1:0] c_o
);
    logic [AW:0] w_diff;
    logic [AW:0] w_wrap;
    logic [AW:0] w_res;

    assign w_diff = {1'b0, a_i} - {1'b0, b_i};
    assign w_wrap = w_diff + {{(AW + 1 - QW){1'b0}}, q_i};
    // Top bit of the difference is the borrow: a < b, so fold q back in.
    assign w_res  = w_diff[AW] ? w_wrap : w_diff;
    // In-range operands always leave the upper bits clear; out-of-range
    // operands saturate to all-ones rather than aliasing to a plausible value.
    assign c_o    = w_res[QW-1:0] | {QW{|w_res[AW:QW]}};
endmodule

module mod_sub_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 24,
    parameter int QW   = 23
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 q_we_i,
    input  logic [QW-1:0]        q_wdata_i,
    output logic [QW-1:0]        q_o,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*AW-1:0]   a_i,
    input  logic [NREQ*AW-1:0]   b_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [QW-1:0]        rsp_data_o,
    output logic [15:0]          op_cnt_o
);
    localparam int LW = $clog2(NREQ);

    logic [QW-1:0]   r_q;
    logic [LW-1:0]   r_last;
    logic [NREQ-1:0] r_rsp_valid;
    logic [QW-1:0]   r_rsp_data;
    logic [15:0]     r_op_cnt;

    logic            w_any;
    logic [LW-1:0]   w_idx;
    logic [NREQ-1:0] w_gnt;
    logic [AW-1:0]   w_a;
    logic [AW-1:0]   w_b;
    logic [QW-1:0]   w_c;

    // Scan from the lane after the last winner, wrapping; first hit wins.
    // An all-zero modulus means unconfigured, so nothing is granted.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int off = 1; off <= NREQ; off++) begin
            int idx;
            idx = (int'(r_last) + off) % NREQ;
            if (!w_any && req_i[idx] && (r_q != '0)) begin
                w_any = 1'b1;
                w_idx = LW'(idx);
            end
        end
    end

    assign w_gnt = w_any ? (NREQ'(1) << w_idx) : '0;

    assign w_a = a_i[w_idx*AW +: AW];
    assign w_b = b_i[w_idx*AW +: AW];

    mod_sub #(
        .AW (AW),
        .QW (QW)
    ) u_mod_sub (
        .a_i (w_a),
        .b_i (w_b),
        .q_i (r_q),
        .c_o (w_c)
    );

    // A modulus write lands at the same edge that captures the current
    // operation, so that operation still sees the old q.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q         <= '0;
            r_last      <= LW'(NREQ - 1);
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_op_cnt    <= '0;
        end else begin
            if (q_we_i) begin
                r_q <= q_wdata_i;
            end
            r_rsp_valid <= w_gnt;
            if (w_any) begin
                r_last     <= w_idx;
                r_rsp_data <= w_c;
                r_op_cnt   <= r_op_cnt + 16'd1;
            end
        end
    end

    assign q_o         = r_q;
    assign gnt_o       = w_gnt;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign op_cnt_o    = r_op_cnt;
endmodule

// File: tb/tb_mod_sub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mod_sub_arbiter
//   Directed bench for mod_sub_arbiter (NREQ=4, AW=24, QW=23). Inputs change
//   1ns after the rising edge; outputs are sampled 1ns later or 1ns after the
//   next edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mod_sub_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 24;
    localparam int QW   = 23;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                q_we_i;
    logic [QW-1:0]       q_wdata_i;
    logic [QW-1:0]       q_o;
    logic [NREQ-1:0]     req_i;
    logic [NREQ*AW-1:0]  a_i;
    logic [NREQ*AW-1:0]  b_i;
    logic [NREQ-1:0]     gnt_o;
    logic [NREQ-1:0]     rsp_valid_o;
    logic [QW-1:0]       rsp_data_o;
    logic [15:0]         op_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    mod_sub_arbiter #(.NREQ(NREQ), .AW(AW), .QW(QW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .q_we_i      (q_we_i),
        .q_wdata_i   (q_wdata_i),
        .q_o         (q_o),
        .req_i       (req_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .gnt_o       (gnt_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .op_cnt_o    (op_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_op(input int lane, input int av, input int bv);
        a_i[lane*AW +: AW] = AW'(av);
        b_i[lane*AW +: AW] = AW'(bv);
    endtask

    // Round-robin operands and their results mod 40
    int rr_a   [4] = '{20, 5, 39, 0};
    int rr_b   [4] = '{13, 30, 39, 1};
    int rr_exp [4] = '{7, 15, 0, 39};

    initial begin
        rst_i     = 1'b1;
        q_we_i    = 1'b0;
        q_wdata_i = '0;
        req_i     = '0;
        a_i       = '0;
        b_i       = '0;

        // Reset values
        repeat (2) tick();
        chk("rst_q",      32'(q_o),         32'd0);
        chk("rst_valid",  32'(rsp_valid_o), 32'd0);
        chk("rst_data",   32'(rsp_data_o),  32'd0);
        chk("rst_cnt",    32'(op_cnt_o),    32'd0);
        chk("rst_gnt",    32'(gnt_o),       32'd0);
        rst_i = 1'b0;

        // Idle gate: q still 0
        tick();
        for (int k = 0; k < NREQ; k++) set_op(k, rr_a[k], rr_b[k]);
        req_i = 4'b1111;
        #1;
        chk("idle_gnt", 32'(gnt_o), 32'd0);
        tick();
        chk("idle_gnt2",  32'(gnt_o),       32'd0);
        chk("idle_cnt",   32'(op_cnt_o),    32'd0);
        chk("idle_valid", 32'(rsp_valid_o), 32'd0);
        req_i = '0;

        // Configure q=40
        q_we_i = 1'b1; q_wdata_i = 23'd40;
        tick();
        q_we_i = 1'b0;
        chk("cfg_q", 32'(q_o), 32'd40);

        // Round robin from reset pointer: 0,1,2,3,0,1,2,3
        req_i = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_gnt", 32'(gnt_o), 32'(1 << (c % 4)));
            tick();
            chk("rr_valid", 32'(rsp_valid_o), 32'(1 << (c % 4)));
            chk("rr_data",  32'(rsp_data_o),  32'(rr_exp[c % 4]));
        end
        req_i = '0;
        chk("rr_cnt", 32'(op_cnt_o), 32'd8);

        // Basic subtraction on lane 0
        set_op(0, 20, 13);
        req_i = 4'b0001;
        #1;
        chk("basic1_gnt", 32'(gnt_o), 32'b0001);
        tick();
        chk("basic1_valid", 32'(rsp_valid_o), 32'b0001);
        chk("basic1_data",  32'(rsp_data_o),  32'd7);
        set_op(0, 7, 13);
        #1;
        chk("basic2_gnt", 32'(gnt_o), 32'b0001);
        tick();
        req_i = '0;
        chk("basic2_valid", 32'(rsp_valid_o), 32'b0001);
        chk("basic2_data",  32'(rsp_data_o),  32'd34);
        chk("basic2_cnt",   32'(op_cnt_o),    32'd10);
        #1;
        chk("nogrant_gnt", 32'(gnt_o), 32'd0);
        tick();
        chk("nogrant_valid", 32'(rsp_valid_o), 32'd0);
        chk("nogrant_hold",  32'(rsp_data_o),  32'd34);

        // q=17 written in the grant cycle: operation uses old q=40
        set_op(0, 5, 9);
        req_i = 4'b0001;
        q_we_i = 1'b1; q_wdata_i = 23'd17;
        #1;
        chk("wq17_gnt", 32'(gnt_o), 32'b0001);
        tick();
        q_we_i = 1'b0;
        req_i  = '0;
        chk("wq17_data", 32'(rsp_data_o), 32'd36);
        chk("wq17_q",    32'(q_o),        32'd17);

        // q=0 written in the grant cycle: that op completes, then grants stop
        set_op(1, 10, 3);
        req_i = 4'b0010;
        q_we_i = 1'b1; q_wdata_i = '0;
        #1;
        chk("wq0_gnt", 32'(gnt_o), 32'b0010);
        tick();
        q_we_i = 1'b0;
        chk("wq0_valid", 32'(rsp_valid_o), 32'b0010);
        chk("wq0_data",  32'(rsp_data_o),  32'd7);
        #1;
        chk("wq0_gnt_off", 32'(gnt_o), 32'd0);
        tick();
        req_i = '0;
        chk("wq0_valid_off", 32'(rsp_valid_o), 32'd0);
        chk("wq0_cnt",       32'(op_cnt_o),    32'd12);

        // Reset mid-stream with a grant pending
        q_we_i = 1'b1; q_wdata_i = 23'd40;
        tick();
        q_we_i = 1'b0;
        set_op(2, 1, 0);
        req_i = 4'b0100;
        #1;
        chk("mid_gnt2", 32'(gnt_o), 32'b0100);
        tick();
        for (int k = 0; k < NREQ; k++) set_op(k, rr_a[k], rr_b[k]);
        req_i = 4'b1111;
        #1;
        chk("mid_gnt3", 32'(gnt_o), 32'b1000);
        #1;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_data",  32'(rsp_data_o),  32'd0);
        chk("mid_rst_gnt",   32'(gnt_o),       32'd0);
        tick();
        chk("mid_rst_valid2", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_cnt",    32'(op_cnt_o),    32'd0);
        rst_i  = 1'b0;
        q_we_i = 1'b1; q_wdata_i = 23'd40;
        tick();
        q_we_i = 1'b0;
        chk("post_rst_valid", 32'(rsp_valid_o), 32'd0);
        #1;
        chk("post_rst_gnt", 32'(gnt_o), 32'b0001);
        tick();
        req_i = '0;
        chk("post_rst_valid2", 32'(rsp_valid_o), 32'b0001);
        chk("post_rst_data",   32'(rsp_data_o),  32'd7);
        chk("post_rst_cnt",    32'(op_cnt_o),    32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
